// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder side of the core's data-memory port. Holds a byte-writable word
// RAM plus a small MMIO block (64-bit machine timer with compare/interrupt and
// a byte-wide transmit FIFO draining to a valid/ready sink).
//
// Optional build macro: DMEM_MTIME_PRESCALE_EN
//   defined   -> 16-bit PRESCALE register at MMIO offset 0x18 slows mtime
//   undefined -> mtime counts every cycle, offset 0x18 reads 0
//
// Ports
//   clk          core clock
//   rst_n        synchronous reset, ACTIVE-HIGH despite the name
//   mem_raddr_i  byte read address (combinational read)
//   mem_rdata_o  read data, combinational from mem_raddr_i
//   mem_waddr_i  byte write address
//   mem_wdata_i  lane-aligned write data
//   mem_we_i     byte write enables, bit n covers bits [8n+7:8n]
//   timer_irq_o  registered level interrupt, mtime >= mtimecmp
//   tx_valid_o   TX FIFO head valid
//   tx_data_o    TX FIFO head byte (0 when empty)
//   tx_ready_i   sink accepts the head byte
//
// MMIO map (offsets from MMIO_BASE)
//   0x00 MTIME_LO   0x04 MTIME_HI   0x08 MTIMECMP_LO   0x0C MTIMECMP_HI
//   0x10 TX_DATA (write-only, lane 0)
//   0x14 STATUS  [0] FULL [1] EMPTY [2] IRQ [3] OVF [4] ERR [8+:n] count
//   0x18 PRESCALE (only with DMEM_MTIME_PRESCALE_EN)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_raddr_i,
  output logic [31:0] mem_rdata_o,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_we_i,
  output logic        timer_irq_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] OFF_MTIME_LO    = 4'd0;
  localparam logic [3:0] OFF_MTIME_HI    = 4'd1;
  localparam logic [3:0] OFF_MTIMECMP_LO = 4'd2;
  localparam logic [3:0] OFF_MTIMECMP_HI = 4'd3;
  localparam logic [3:0] OFF_TX_DATA     = 4'd4;
  localparam logic [3:0] OFF_STATUS      = 4'd5;
  localparam logic [3:0] OFF_PRESCALE    = 4'd6;

  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  // The reset port keeps its legacy name but is active-high.
  logic srst;
  assign srst = rst_n;

  // Byte-offset bits are ignored by the decoder.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{mem_raddr_i[1:0], mem_waddr_i[1:0]};

  // Replace only the enabled byte lanes of a 32-bit word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  we);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode (word granularity)
  // ---------------------------------------------------------------------------
  logic       ram_rhit, mmio_rhit, ram_whit, mmio_whit;
  logic [3:0] roff, woff;
  logic       wr_any, ram_wr, mmio_wr, unmapped_wr;

  assign ram_rhit  = (mem_raddr_i[31:AW+2] == '0);
  assign ram_whit  = (mem_waddr_i[31:AW+2] == '0);
  assign mmio_rhit = (mem_raddr_i[31:6] == MMIO_BASE[31:6]);
  assign mmio_whit = (mem_waddr_i[31:6] == MMIO_BASE[31:6]);
  assign roff      = mem_raddr_i[5:2];
  assign woff      = mem_waddr_i[5:2];

  assign wr_any      = |mem_we_i;
  assign ram_wr      = wr_any && ram_whit;
  assign mmio_wr     = wr_any && mmio_whit;
  assign unmapped_wr = wr_any && !ram_whit && !mmio_whit;

  // ---------------------------------------------------------------------------
  // RAM: one byte array per lane so each lane writes independently.
  // Contents are not reset.
  // ---------------------------------------------------------------------------
  logic [31:0] ram_rdata;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram_lane [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (ram_wr && mem_we_i[gi]) begin
          ram_lane[mem_waddr_i[AW+1:2]] <= mem_wdata_i[8*gi +: 8];
        end
      end

      assign ram_rdata[8*gi +: 8] = ram_lane[mem_raddr_i[AW+1:2]];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Machine timer
  // ---------------------------------------------------------------------------
  logic [31:0] mtime_lo_reg, mtime_hi_reg;
  logic [31:0] mtimecmp_lo_reg, mtimecmp_hi_reg;
  logic        irq_reg;
  logic        mtime_tick;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
  logic [31:0] prescale_rdata;

  assign wr_mtime_lo = mmio_wr && (woff == OFF_MTIME_LO);
  assign wr_mtime_hi = mmio_wr && (woff == OFF_MTIME_HI);
  assign wr_cmp_lo   = mmio_wr && (woff == OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = mmio_wr && (woff == OFF_MTIMECMP_HI);

`ifdef DMEM_MTIME_PRESCALE_EN
  logic [15:0] prescale_reg, prescale_cnt_reg;
  logic        wr_prescale;

  assign wr_prescale = mmio_wr && (woff == OFF_PRESCALE);

  // Counter runs 0..PRESCALE; mtime advances on the terminal count.
  always_ff @(posedge clk) begin
    if (srst) begin
      prescale_reg     <= '0;
      prescale_cnt_reg <= '0;
    end else if (wr_prescale) begin
      if (mem_we_i[0]) prescale_reg[7:0]  <= mem_wdata_i[7:0];
      if (mem_we_i[1]) prescale_reg[15:8] <= mem_wdata_i[15:8];
      prescale_cnt_reg <= '0;
    end else if (prescale_cnt_reg == prescale_reg) begin
      prescale_cnt_reg <= '0;
    end else begin
      prescale_cnt_reg <= prescale_cnt_reg + 16'd1;
    end
  end

  assign mtime_tick     = (prescale_cnt_reg == prescale_reg);
  assign prescale_rdata = {16'h0000, prescale_reg};
`else
  assign mtime_tick     = 1'b1;
  assign prescale_rdata = 32'h0000_0000;
`endif

  // A write to either half of mtime holds off the increment for that cycle,
  // so software sees exactly the value it wrote.
  always_ff @(posedge clk) begin
    if (srst) begin
      mtime_lo_reg <= '0;
      mtime_hi_reg <= '0;
    end else if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime_lo_reg <= lane_merge(mtime_lo_reg, mem_wdata_i, mem_we_i);
      if (wr_mtime_hi) mtime_hi_reg <= lane_merge(mtime_hi_reg, mem_wdata_i, mem_we_i);
    end else if (mtime_tick) begin
      {mtime_hi_reg, mtime_lo_reg} <= {mtime_hi_reg, mtime_lo_reg} + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      mtimecmp_lo_reg <= '1;
      mtimecmp_hi_reg <= '1;
    end else begin
      if (wr_cmp_lo) mtimecmp_lo_reg <= lane_merge(mtimecmp_lo_reg, mem_wdata_i, mem_we_i);
      if (wr_cmp_hi) mtimecmp_hi_reg <= lane_merge(mtimecmp_hi_reg, mem_wdata_i, mem_we_i);
    end
  end

  // Compare uses the pre-edge values; the interrupt appears one cycle later.
  always_ff @(posedge clk) begin
    if (srst) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= ({mtime_hi_reg, mtime_lo_reg} >= {mtimecmp_hi_reg, mtimecmp_lo_reg});
    end
  end

  assign timer_irq_o = irq_reg;

  // ---------------------------------------------------------------------------
  // TX FIFO: pointers carry an extra wrap bit so full and empty differ.
  // ---------------------------------------------------------------------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0] fifo_count;
  logic        fifo_full, fifo_empty;
  logic        push_req, push_ok, pop, ovf_set;

  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);

  assign push_req = mmio_wr && (woff == OFF_TX_DATA) && mem_we_i[0];
  assign pop      = !fifo_empty && tx_ready_i;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok && !srst) begin
      fifo_mem[wr_ptr_reg[PW-1:0]] <= mem_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg[PW-1:0]];

  // ---------------------------------------------------------------------------
  // STATUS sticky bits (write-1-to-clear through lane 0)
  // ---------------------------------------------------------------------------
  logic ovf_reg, err_reg;
  logic status_wr;

  assign status_wr = mmio_wr && (woff == OFF_STATUS) && mem_we_i[0];

  always_ff @(posedge clk) begin
    if (srst) begin
      ovf_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      if (ovf_set)                          ovf_reg <= 1'b1;
      else if (status_wr && mem_wdata_i[3]) ovf_reg <= 1'b0;

      if (unmapped_wr)                      err_reg <= 1'b1;
      else if (status_wr && mem_wdata_i[4]) err_reg <= 1'b0;
    end
  end

  logic [31:0] status_word;

  always_comb begin
    status_word             = '0;
    status_word[0]          = fifo_full;
    status_word[1]          = fifo_empty;
    status_word[2]          = irq_reg;
    status_word[3]          = ovf_reg;
    status_word[4]          = err_reg;
    status_word[8 +: PW+1]  = fifo_count;
  end

  // ---------------------------------------------------------------------------
  // Read path: purely combinational, no side effects
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    case (roff)
      OFF_MTIME_LO:    mmio_rdata = mtime_lo_reg;
      OFF_MTIME_HI:    mmio_rdata = mtime_hi_reg;
      OFF_MTIMECMP_LO: mmio_rdata = mtimecmp_lo_reg;
      OFF_MTIMECMP_HI: mmio_rdata = mtimecmp_hi_reg;
      OFF_STATUS:      mmio_rdata = status_word;
      OFF_PRESCALE:    mmio_rdata = prescale_rdata;
      default:         mmio_rdata = '0;
    endcase
  end

  always_comb begin
    mem_rdata_o = '0;
    if (ram_rhit)       mem_rdata_o = ram_rdata;
    else if (mmio_rhit) mem_rdata_o = mmio_rdata;
  end

endmodule
